// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int MUL_W = 32;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_FLOAT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mul_arb_state_t;

endpackage

// File: rtl/mul_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NUM_REQ.
module mul_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int IDW = $clog2(NUM_REQ);

  int idx;

  // NOTE: every output of this always_comb gets a default before the loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx       = 0;
    winner    = '0;
    grant     = '0;
    any_valid = |valid;
    // Scan from farthest to nearest so the last hit is the closest one to ptr.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (valid[idx]) begin
        winner = idx[IDW-1:0];
      end
    end
    grant[winner] = any_valid;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit multiplier between NUM_REQ requesters.
// Optional WAIT timeout is built when MUL_ARB_TIMEOUT_EN is defined.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_mode_i,
  input  logic [NUM_REQ*MUL_W-1:0]   req_a_i,
  input  logic [NUM_REQ*MUL_W-1:0]   req_b_i,
  output logic                       mul_start_o,
  output logic                       mul_mode_o,
  output logic [MUL_W-1:0]           mul_a_o,
  output logic [MUL_W-1:0]           mul_b_o,
  input  logic                       mul_done_i,
  input  logic [MUL_W-1:0]           mul_y_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [MUL_W-1:0]           rsp_data_o,
  output logic                       rsp_err_o
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mul_share_arbiter: parameter out of range");
  end

  mul_arb_state_t     state;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     winner;
  logic               any_valid;
  logic               timeout;

  mul_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Ready is gated by reset so every output reads 0 while rst_i is held.
  assign req_ready_o = (state == ST_IDLE && !rst_i) ? grant : '0;
  assign mul_start_o = (state == ST_ISSUE);
  assign rsp_valid_o = (state == ST_RESP);

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

  logic [TW-1:0] wait_cnt;

  assign timeout = (state == ST_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A done strobe on the timeout cycle wins and yields a normal response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_o <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (mul_done_i) begin
        rsp_err_o <= 1'b0;
      end else if (timeout) begin
        rsp_err_o <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // NOTE: all state in this block uses non-blocking assignment so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      mul_mode_o <= 1'b0;
      mul_a_o    <= '0;
      mul_b_o    <= '0;
      rsp_id_o   <= '0;
      rsp_data_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            mul_mode_o <= req_mode_i[winner];
            mul_a_o    <= req_a_i[MUL_W*winner +: MUL_W];
            mul_b_o    <= req_b_i[MUL_W*winner +: MUL_W];
            rsp_id_o   <= winner;
            rr_ptr     <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (mul_done_i) begin
            rsp_data_o <= mul_y_i;
            state      <= ST_RESP;
          end else if (timeout) begin
            rsp_data_o <= '0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed table, hand sequences
// and randomized traffic against a round-robin reference model.
module tb_mul_share_arbiter;
  import mul_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o, req_mode_i;
  logic [N*32-1:0] req_a_i, req_b_i;
  logic            mul_start_o, mul_mode_o;
  logic [31:0]     mul_a_o, mul_b_o;
  logic            mul_done_i;
  logic [31:0]     mul_y_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [1:0]      rsp_id_o;
  logic [31:0]     rsp_data_o;
  logic            rsp_err_o;

  logic        stub_done, man_done, stub_en;
  logic [31:0] stub_y, man_y;
  int          stub_lat;

  assign mul_done_i = stub_done | man_done;
  assign mul_y_i    = man_done ? man_y : stub_y;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic        op_m [N];

  typedef struct {
    logic [N-1:0] mask;
    int           win;
  } arb_vec_t;

  mul_share_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mode_i(req_mode_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .mul_start_o(mul_start_o), .mul_mode_o(mul_mode_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_y_i(mul_y_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in multiplier: Q16.16 product for fixed; the directed float case
  // is exact, other float operands get an arbitrary but deterministic value.
  function automatic logic [31:0] mul_fn(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (m == MODE_FIXED) begin
      p = {32'b0, a} * {32'b0, b};
      return p[47:16];
    end
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int k, input logic m, input logic [31:0] a, input logic [31:0] b);
    op_m[k] = m;
    op_a[k] = a;
    op_b[k] = b;
    req_mode_i[k]        = m;
    req_a_i[32*k +: 32]  = a;
    req_b_i[32*k +: 32]  = b;
  endtask

  // One full transaction: offer mask, expect exp_win, multiplier answers after
  // lat cycles, consumer stalls the response for hold cycles.
  task automatic run_txn(input logic [N-1:0] mask, input int exp_win, input int lat,
                         input int hold, input string tag);
    int           n;
    logic [31:0]  exp_y;
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_win] = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = mask;
    stub_lat    = lat;
    rsp_ready_i = (hold == 0);
    @(negedge clk_i);
    check({tag, " grant"}, 32'(req_ready_o), 32'(oh));
    m_ptr = (exp_win + 1) % N;
    exp_y = mul_fn(op_m[exp_win], op_a[exp_win], op_b[exp_win]);
    @(posedge clk_i); #1;
    req_valid_i = mask & ~oh;
    @(negedge clk_i);
    check({tag, " start"}, 32'(mul_start_o), 32'd1);
    check({tag, " mul_a"}, mul_a_o, op_a[exp_win]);
    check({tag, " mul_b"}, mul_b_o, op_b[exp_win]);
    check({tag, " mul_mode"}, 32'(mul_mode_o), 32'(op_m[exp_win]));
    check({tag, " ready busy"}, 32'(req_ready_o), 32'd0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rsp_valid_o && n < 200);
    check({tag, " latency"}, 32'(n), 32'(lat + 1));
    check({tag, " rsp_id"}, 32'(rsp_id_o), 32'(exp_win));
    check({tag, " rsp_data"}, rsp_data_o, exp_y);
    check({tag, " rsp_err"}, 32'(rsp_err_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({tag, " held valid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, " held data"}, rsp_data_o, exp_y);
      check({tag, " held ready"}, 32'(req_ready_o), 32'd0);
      check({tag, " held start"}, 32'(mul_start_o), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
    end
  endtask

  initial begin : stub
    logic [31:0] y;
    stub_done = 1'b0;
    stub_y    = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mul_start_o && stub_en) begin
        y = mul_fn(mul_mode_o, mul_a_o, mul_b_o);
        repeat (stub_lat) begin
          @(posedge clk_i); #1;
        end
        stub_done = 1'b1;
        stub_y    = y;
        @(posedge clk_i); #1;
        stub_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin : main
    arb_vec_t     tbl [8];
    logic [N-1:0] pend;
    int           n, bad, w;

    rst_i       = 1'b1;
    req_valid_i = '1;
    rsp_ready_i = 1'b1;
    man_done    = 1'b0;
    man_y       = '0;
    stub_en     = 1'b1;
    stub_lat    = 3;
    req_mode_i  = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    for (int k = 0; k < N; k++)
      set_op(k, k[0], 32'h0001_0000 * (k + 2), 32'h0000_8000 * (k + 1));

    // Reset state, with every requester asking.
    @(negedge clk_i);
    check("rst req_ready", 32'(req_ready_o), 32'd0);
    check("rst start", 32'(mul_start_o), 32'd0);
    check("rst mul_a", mul_a_o, 32'd0);
    check("rst mul_mode", 32'(mul_mode_o), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst rsp_data", rsp_data_o, 32'd0);
    check("rst rsp_id", 32'(rsp_id_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    req_valid_i = '0;

    // Arbitration table, pointer starts at 0.
    tbl[0] = '{4'b0001, 0};
    tbl[1] = '{4'b0001, 0};
    tbl[2] = '{4'b1001, 3};
    tbl[3] = '{4'b1111, 0};
    tbl[4] = '{4'b0101, 2};
    tbl[5] = '{4'b0011, 0};
    tbl[6] = '{4'b0010, 1};
    tbl[7] = '{4'b1010, 3};
    for (int i = 0; i < 8; i++) run_txn(tbl[i].mask, tbl[i].win, 2, 0, "table");

    // Fairness: everyone asking, order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_txn(4'b1111, i % N, 1 + i, 0, "fair");

    // Single float request from requester 1.
    set_op(1, MODE_FLOAT, 32'h4000_0000, 32'h4040_0000);
    run_txn(4'b0010, 1, 3, 0, "single");
    check("single data", rsp_data_o, 32'h40C0_0000);

    // Backpressure: response held 10 cycles with all others asking.
    run_txn(4'b1111, 2, 2, 10, "bp");

    // Stray done in IDLE, then fixed request from requester 3.
    @(posedge clk_i); #1;
    req_valid_i = '0;
    man_done    = 1'b1;
    man_y       = 32'hBAD0_BAD0;
    @(negedge clk_i);
    check("stray idle ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    man_done = 1'b0;
    @(negedge clk_i);
    check("stray idle rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("stray idle start", 32'(mul_start_o), 32'd0);
    set_op(3, MODE_FIXED, 32'h0003_0000, 32'h0002_0000);
    run_txn(4'b1000, 3, 2, 0, "fixed");
    check("fixed data", rsp_data_o, 32'h0006_0000);
    check("fixed mode", 32'(mul_mode_o), 32'(MODE_FIXED));

    // Done during ISSUE is ignored; a later done in WAIT completes.
    stub_en = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    check("issue grant", 32'(req_ready_o), 32'b0100);
    m_ptr = 3;
    @(posedge clk_i); #1;
    req_valid_i = '0;
    man_done    = 1'b1;
    man_y       = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("issue start", 32'(mul_start_o), 32'd1);
    @(posedge clk_i); #1;
    man_done = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (rsp_valid_o) bad++;
    end
    check("issue stray ignored", 32'(bad), 32'd0);
    @(posedge clk_i); #1;
    man_done = 1'b1;
    man_y    = 32'h1234_5678;
    @(posedge clk_i); #1;
    man_done = 1'b0;
    @(negedge clk_i);
    check("issue late valid", 32'(rsp_valid_o), 32'd1);
    check("issue late data", rsp_data_o, 32'h1234_5678);
    check("issue late id", 32'(rsp_id_o), 32'd2);
    stub_en = 1'b1;

    // Reset while in WAIT; the late done must not produce a response.
    set_op(1, MODE_FLOAT, 32'h3F80_0001, 32'hC000_0002);
    stub_lat = 6;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    check("rstwait grant", 32'(req_ready_o), 32'b0010);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstwait mul_a", mul_a_o, 32'd0);
    check("rstwait mul_b", mul_b_o, 32'd0);
    check("rstwait mul_mode", 32'(mul_mode_o), 32'd0);
    check("rstwait rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rstwait rsp_id", 32'(rsp_id_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_ptr = 0;
    bad = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (rsp_valid_o || mul_start_o) bad++;
    end
    check("rstwait late done ignored", 32'(bad), 32'd0);
    run_txn(4'b0101, 0, 2, 0, "post-reset");

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier never answers: error response after TO WAIT cycles.
    stub_en = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    check("timeout grant", 32'(req_ready_o), 32'b0001);
    m_ptr = 1;
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    check("timeout start", 32'(mul_start_o), 32'd1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rsp_valid_o && n < 100);
    check("timeout latency", 32'(n), 32'(TO + 1));
    check("timeout err", 32'(rsp_err_o), 32'd1);
    check("timeout data", rsp_data_o, 32'd0);
    check("timeout id", 32'(rsp_id_o), 32'd0);
    stub_en = 1'b1;
`endif

    // Randomized traffic against the round-robin reference model.
    pend = '0;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          pend[k] = 1'b1;
          set_op(k, 1'($urandom_range(1, 0)), $urandom, $urandom);
        end
      end
      if (pend == '0) begin
        @(posedge clk_i); #1;
        req_valid_i = '0;
        @(negedge clk_i);
        check("rand idle ready", 32'(req_ready_o), 32'd0);
      end else begin
        w = -1;
        for (int i = N - 1; i >= 0; i--) begin
          if (pend[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        end
        run_txn(pend, w, $urandom_range(6, 1), $urandom_range(3, 0), "rand");
        pend[w] = 1'b0;
      end
    end

    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that shares one 32-bit fixed/floating-point multiplier between `NUM_REQ` requesters. Each requester submits an operand pair and a mode over a valid/ready handshake. The block grants one requester at a time, launches the multiplier with a start pulse, waits for its done strobe, and returns the result tagged with the requester index. It sits between the requesting datapath blocks and the multiplier core.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in WAIT; used only when `MUL_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in `NUM_REQ`: per-requester request valid.
- `req_ready_o` out `NUM_REQ`: per-requester grant/accept; one-hot or zero.
- `req_mode_i` in `NUM_REQ`: per-requester mode; 1 = float, 0 = fixed.
- `req_a_i` in `NUM_REQ*32`: operand A; requester k occupies bits `[32k+31:32k]`.
- `req_b_i` in `NUM_REQ*32`: operand B, packed the same way as `req_a_i`.
- `mul_start_o` out 1: one-cycle launch pulse to the multiplier.
- `mul_mode_o` out 1: mode of the captured request, driven to the multiplier.
- `mul_a_o` out 32: operand A of the captured request, driven to the multiplier.
- `mul_b_o` out 32: operand B of the captured request, driven to the multiplier.
- `mul_done_i` in 1: multiplier result-valid strobe.
- `mul_y_i` in 32: multiplier result.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_id_o` out `$clog2(NUM_REQ)`: index of the requester that owns the response.
- `rsp_data_o` out 32: response data.
- `rsp_err_o` out 1: response is a timeout error.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Arbitration is combinational. The winner is the first k with `req_valid_i[k]`=1, searching upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - `req_ready_o[winner]`=1 in the same cycle.
  - On that cycle's edge the block captures the winner's mode, a and b into `mul_*_o`, captures `rsp_id_o`=winner, sets `rr_ptr`=(winner+1) mod `NUM_REQ`, and moves to ISSUE.
  - With no valid request, the FSM stays in IDLE and `req_ready_o`=0.
- **ISSUE**: `mul_start_o`=1 for exactly this cycle; next state is WAIT.
- **WAIT**: on `mul_done_i`=1, capture `rsp_data_o`=`mul_y_i` and `rsp_err_o`=0, then go to RESP.
- **RESP**: `rsp_valid_o`=1 and held. When `rsp_valid_o` and `rsp_ready_i` are both 1, return to IDLE.
- `req_ready_o` is 0 in every state except IDLE. A requester must hold `req_valid_i` and its operands stable until it is accepted.
- `mul_mode_o`, `mul_a_o` and `mul_b_o` stay stable from ISSUE through the end of RESP.
- `mul_done_i` is ignored outside WAIT. A done strobe in the same cycle as ISSUE is also ignored.
- The block performs no arithmetic on data; `mul_y_i` is passed through bit-exact.

## Timing
- Reset value of all outputs is 0. Reset also sets state to IDLE and `rr_ptr`=0.
- Reset asserted mid-operation:
  - The in-flight result is discarded and no response is emitted.
  - The multiplier itself is not reset by this block.
  - A `mul_done_i` arriving after reset is ignored.
- Accept at cycle T. `mul_start_o` is high at T+1. With `mul_done_i` at cycle D ≥ T+2, `rsp_valid_o` is high from D+1.
- Minimum request-to-response latency is 3 cycles.
- Minimum throughput is one operation per 4 cycles (RESP and IDLE are not overlapped).
- A held response (`rsp_ready_i`=0) stalls all requesters; no accept happens while in RESP.
- A single active requester is granted on every IDLE visit; the pointer wraps from `NUM_REQ-1` to 0.

## Configuration
- `MUL_ARB_TIMEOUT_EN` defined:
  - A 5-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If `TIMEOUT_CYCLES` WAIT cycles elapse without `mul_done_i`, go to RESP with `rsp_err_o`=1 and `rsp_data_o`=0.
  - A done strobe on the same cycle the timeout fires has priority (normal response).
- `MUL_ARB_TIMEOUT_EN` undefined: no counter is built, `rsp_err_o` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `mul_arb_pkg` holds:
  - the state enum typedef `mul_arb_state_t`;
  - `MUL_W`=32;
  - `MODE_FIXED`=1'b0 and `MODE_FLOAT`=1'b1.
- Sub-module `mul_rr_pick`: combinational round-robin picker. Inputs are the valid vector and the pointer; outputs are the one-hot grant, the winner index and `any_valid`.

## Test plan
- **Single request**: requester 1 requests float, a=32'h40000000, b=32'h40400000. The model returns 32'h40C00000 after 3 cycles. Expect `rsp_id_o`=1, `rsp_data_o`=32'h40C00000, `rsp_err_o`=0, and `rsp_valid_o` 4 cycles after `mul_start_o`.
- **Fairness**: all 4 valid continuously. Expect grant order 0,1,2,3,0, one `mul_start_o` per grant, and a response id matching each grant.
- **Backpressure**: `rsp_ready_i`=0 for 10 cycles. Expect `rsp_valid_o`/`rsp_data_o` held, `req_ready_o`=0, and no new `mul_start_o`.
- **Fixed mode and stray done**: requester 3 requests fixed, a=32'h00030000, b=32'h00020000; the bench pulses `mul_done_i` during IDLE. Expect the stray pulse to be ignored, and `mul_mode_o`=0 with operands passed unchanged.
- **Reset in WAIT**: assert `rst_i` while in WAIT. Expect all outputs 0 immediately. A later `mul_done_i` produces no response, and the next grant goes to requester 0.
- **Timeout** (`MUL_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): the model never raises done. Expect a response 16 WAIT cycles after entering WAIT with `rsp_err_o`=1 and `rsp_data_o`=0.
